// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, hazard status codes and sequencer state enum.
package mdu_sequencer_pkg;

   localparam logic [1:0] MDU_MUL   = 2'b00;
   localparam logic [1:0] MDU_MULHU = 2'b01;
   localparam logic [1:0] MDU_DIVU  = 2'b10;
   localparam logic [1:0] MDU_REMU  = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_RETIRE = 2'b01;
   localparam logic [1:0] ST_BUSY   = 2'b10;
   localparam logic [1:0] ST_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mdu_state_t;

   function automatic logic is_div_op(input logic [1:0] op);
      return (op == MDU_DIVU) || (op == MDU_REMU);
   endfunction

endpackage

// File: rtl/mdu_iter_datapath.sv
// One combinational iteration of shift-add multiply or
// restoring unsigned divide over a {hi, lo} accumulator.
module mdu_iter_datapath #(
   parameter int DATA_W = 16
) (
   input  logic                  is_div,
   input  logic [2*DATA_W-1:0]   acc,
   input  logic [DATA_W-1:0]     operand,
   output logic [2*DATA_W-1:0]   acc_next
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   // mul: hi += multiplicand if lsb set, then shift right;
   // div: shift {rem,quo} left, trial-subtract divisor
   always_comb begin
      sum     = {1'b0, acc[2*DATA_W-1:DATA_W]}
              + (acc[0] ? {1'b0, operand} : '0);
      shifted = acc[2*DATA_W-1:DATA_W-1];
      diff    = shifted - {1'b0, operand};
      acc_next = {sum, acc[DATA_W-1:1]};
      if (is_div) begin
         if (diff[DATA_W]) begin
            acc_next = {shifted[DATA_W-1:0],
                        acc[DATA_W-2:0], 1'b0};
         end else begin
            acc_next = {diff[DATA_W-1:0],
                        acc[DATA_W-2:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Sequencer for the iterative 16-bit MUL/DIV unit in EX.
// Owns FSM, counter, operand/accumulator regs, result mux.
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              flush,
   input  logic              wb_ready,
   output logic [1:0]        alu_status,
   output logic              res_valid,
   output logic [DATA_W-1:0] result,
   output logic [REG_W-1:0]  res_rd,
   output logic              dbz
);

   mdu_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [1:0]          op_q;
   logic [DATA_W-1:0]   opnd_q;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] acc_next;
   logic [REG_W-1:0]    rd_q;
   logic                dbz_q;
   logic                done;

   mdu_iter_datapath #(
      .DATA_W (DATA_W)
   ) u_step (
      .is_div   (is_div_op(op_q)),
      .acc      (acc),
      .operand  (opnd_q),
      .acc_next (acc_next)
   );

   // FSM: accept in IDLE, iterate in BUSY, hold in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         opnd_q <= '0;
         acc    <= '0;
         rd_q   <= '0;
         dbz_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !flush) begin
                  op_q <= op;
                  rd_q <= rd_in;
                  cnt  <= CNT_W'(DATA_W);
                  if (is_div_op(op)) begin
                     opnd_q <= opb;
                  end else begin
                     opnd_q <= opa;
                  end
                  if (is_div_op(op) && opb == '0) begin
                     acc   <= {opa, {DATA_W{1'b1}}};
                     dbz_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     acc   <= is_div_op(op)
                            ? {{DATA_W{1'b0}}, opa}
                            : {{DATA_W{1'b0}}, opb};
                     dbz_q <= 1'b0;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (flush || wb_ready) begin
                  cnt   <= '0;
                  dbz_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done      = (state == DONE);
   assign res_valid = done;
   assign res_rd    = done ? rd_q : '0;
   assign dbz       = done & dbz_q;

   // low/high accumulator half chosen by op; zero unless held
   always_comb begin
      result = '0;
      if (done) begin
         unique case (op_q)
            MDU_MUL:   result = acc[DATA_W-1:0];
            MDU_MULHU: result = acc[2*DATA_W-1:DATA_W];
            MDU_DIVU:  result = acc[DATA_W-1:0];
            MDU_REMU:  result = acc[2*DATA_W-1:DATA_W];
            default:   result = '0;
         endcase
      end
   end

   // hazard status from state and wb_ready only
   always_comb begin
      alu_status = ST_IDLE;
      unique case (state)
         IDLE:    alu_status = ST_IDLE;
         BUSY:    alu_status = ST_BUSY;
         DONE:    alu_status = wb_ready ? ST_RETIRE : ST_HOLD;
         default: alu_status = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer.
// Directed plan steps plus random ops vs arithmetic model.
module tb_mdu_sequencer;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] opa = '0;
   logic [15:0] opb = '0;
   logic [3:0]  rd_in = '0;
   logic        flush = 1'b0;
   logic        wb_ready = 1'b0;
   logic [1:0]  alu_status;
   logic        res_valid;
   logic [15:0] result;
   logic [3:0]  res_rd;
   logic        dbz;

   int checks = 0;
   int errors = 0;

   mdu_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .op         (op),
      .opa        (opa),
      .opb        (opb),
      .rd_in      (rd_in),
      .flush      (flush),
      .wb_ready   (wb_ready),
      .alu_status (alu_status),
      .res_valid  (res_valid),
      .result     (result),
      .res_rd     (res_rd),
      .dbz        (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [1:0] o,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
      logic [31:0] p;
      p = 32'(a) * 32'(b);
      case (o)
         2'd0:    return p[15:0];
         2'd1:    return p[31:16];
         2'd2:    return (b == 0) ? 16'hFFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, ".status"}, 32'(alu_status), 32'd0);
      chk({tag, ".valid"}, 32'(res_valid), 32'd0);
      chk({tag, ".result"}, 32'(result), 32'd0);
      chk({tag, ".rd"}, 32'(res_rd), 32'd0);
      chk({tag, ".dbz"}, 32'(dbz), 32'd0);
   endtask

   task automatic run(input logic [1:0] o,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic [3:0] rd,
                      input int hold);
      logic [15:0] exp;
      logic        z;
      int          lat;
      exp = model(o, a, b);
      z   = o[1] && (b == 0);
      lat = z ? 1 : W + 1;
      @(negedge clk);
      start = 1'b1;
      op = o; opa = a; opb = b; rd_in = rd;
      wb_ready = 1'b0;
      for (int c = 1; c < lat; c++) begin
         @(negedge clk);
         start = 1'b0;
         op = 2'($urandom);
         opa = 16'($urandom);
         opb = 16'($urandom);
         rd_in = 4'($urandom);
         wb_ready = 1'($urandom);
         #1;
         chk("busy.status", 32'(alu_status), 32'd2);
         chk("busy.valid", 32'(res_valid), 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      wb_ready = (hold == 0);
      #1;
      chk("done.valid", 32'(res_valid), 32'd1);
      chk("done.result", 32'(result), 32'(exp));
      chk("done.rd", 32'(res_rd), 32'(rd));
      chk("done.dbz", 32'(dbz), 32'(z));
      chk("done.status", 32'(alu_status),
          (hold == 0) ? 32'd1 : 32'd3);
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         start = (h == 1);
         #1;
         chk("hold.status", 32'(alu_status), 32'd3);
         chk("hold.result", 32'(result), 32'(exp));
         chk("hold.valid", 32'(res_valid), 32'd1);
      end
      if (hold > 0) begin
         @(negedge clk);
         wb_ready = 1'b1;
         start = 1'b1;
         #1;
         chk("retire.status", 32'(alu_status), 32'd1);
         chk("retire.result", 32'(result), 32'(exp));
      end
      @(negedge clk);
      wb_ready = 1'b0;
      start = 1'b0;
      #1;
      check_idle("retired");
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;

      run(2'd0, 16'h1234, 16'h0010, 4'h1, 0);
      run(2'd1, 16'hFFFF, 16'hFFFF, 4'h7, 0);
      run(2'd0, 16'hFFFF, 16'hFFFF, 4'h7, 1);
      run(2'd2, 16'd100, 16'd7, 4'h2, 0);
      run(2'd3, 16'd100, 16'd7, 4'h3, 2);
      run(2'd2, 16'hFFFF, 16'h0001, 4'h4, 0);
      run(2'd2, 16'h1234, 16'h0000, 4'h5, 0);
      run(2'd3, 16'h1234, 16'h0000, 4'h6, 3);
      run(2'd0, 16'h00FF, 16'h0101, 4'h8, 3);

      // start with flush in IDLE is dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1;
      op = 2'd0; opa = 16'd3; opb = 16'd5;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      check_idle("startflush");

      // flush during BUSY cycle 8
      @(negedge clk);
      start = 1'b1;
      op = 2'd0; opa = 16'd3; opb = 16'd5; rd_in = 4'hA;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
         flush = (c == 8);
         #1;
         chk("flbusy.status", 32'(alu_status), 32'd2);
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_idle("flushbusy");

      // flush beats wb_ready in DONE
      @(negedge clk);
      start = 1'b1;
      op = 2'd2; opa = 16'h1234; opb = 16'h0000; rd_in = 4'hB;
      @(negedge clk);
      start = 1'b0; flush = 1'b1; wb_ready = 1'b1;
      #1;
      chk("fldone.valid", 32'(res_valid), 32'd1);
      chk("fldone.dbz", 32'(dbz), 32'd1);
      @(negedge clk);
      flush = 1'b0; wb_ready = 1'b0;
      #1;
      check_idle("flushdone");

      // async reset during BUSY cycle 5
      @(negedge clk);
      start = 1'b1;
      op = 2'd1; opa = 16'hBEEF; opb = 16'h1234; rd_in = 4'hC;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      chk("rstmid.pre", 32'(alu_status), 32'd2);
      rst_n = 1'b0;
      #1;
      check_idle("rstmid");
      @(negedge clk);
      rst_n = 1'b1;
      run(2'd0, 16'd3, 16'd5, 4'h9, 0);

      // random ops against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
         run(2'($urandom), ra, rb, 4'($urandom),
             int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Sequences the iterative 16-bit multiply/divide unit that sits beside the single-cycle ALU in EX.
- Accepts one operation at a time from ID/EX and runs one iteration per cycle.
- Holds the result until the writeback path takes it.
- Drives the 2-bit alu_status that hazard control uses to stall IF/ID and ID/EX: any value above 2'b01 stalls.

Parameters:
- DATA_W, 16, operand/result width; also the iteration count.
- REG_W, 4, destination register index width.
- CNT_W, 5, iteration counter width; must be at least clog2(DATA_W+1).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  00 MUL (low half), 01 MULHU (high half, unsigned), 10 DIVU, 11 REMU
- opa  in  DATA_W  multiplicand / dividend
- opb  in  DATA_W  multiplier / divisor
- rd_in  in  REG_W  destination register, carried with the op
- flush  in  1  kill any in-flight or held op (branch redirect)
- wb_ready  in  1  writeback accepts the result this cycle
- alu_status  out  2  00 idle, 10 busy, 11 done-held, 01 done-retiring
- res_valid  out  1  result and res_rd are valid
- result  out  DATA_W  selected result
- res_rd  out  REG_W  destination register of the result
- dbz  out  1  the held result came from a divide by zero

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all outputs 0, internal operand/accumulator registers 0. Reset is effective at any point, including mid-iteration; no partial result survives.
- State IDLE:
  - start=1 and flush=0: latch op, opa, opb, rd_in; load counter=DATA_W; next state BUSY.
  - start=1 and flush=1: flush wins; start is dropped and state stays IDLE.
  - DIVU/REMU with opb==0: skip BUSY and go straight to DONE. Quotient=all ones, remainder=opa, dbz=1.
- State BUSY:
  - One iteration per cycle; the counter decrements each cycle.
  - MUL/MULHU: shift-add into a 2*DATA_W unsigned accumulator.
  - DIVU/REMU: restoring division, unsigned.
  - When the counter reaches 1 and that iteration completes, go to DONE.
  - Latency: res_valid first asserts exactly DATA_W+1 cycles after the edge that accepted start (cycle 17 at default).
- State DONE:
  - res_valid=1; result, res_rd and dbz stay stable while held.
  - wb_ready=1: alu_status=01 that cycle; next state IDLE; res_valid drops next cycle.
  - wb_ready=0: alu_status=11; remain in DONE indefinitely.
- start outside IDLE is ignored and not queued, even in DONE with wb_ready=1. The next op needs at least one IDLE cycle.
- flush in BUSY or DONE: next state IDLE; res_valid, dbz and alu_status go to 0 the next cycle; no result is retired. If flush=1 and wb_ready=1 in the same DONE cycle, flush wins.
- alu_status is decoded from state and wb_ready only: IDLE→00, BUSY→10, DONE→11 or 01.
- Width rules:
  - Results are DATA_W bits.
  - MUL returns product[DATA_W-1:0]; MULHU returns product[2*DATA_W-1:DATA_W].
  - The divider partial remainder is DATA_W+1 bits so the subtract-compare keeps its sign.
- Operands are latched at accept; input changes during BUSY have no effect.

Decomposition:
- Shared package holds:
  - op encodings (MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU)
  - alu_status codes (ST_IDLE=00, ST_RETIRE=01, ST_BUSY=10, ST_HOLD=11), shared with hazard_control
  - the FSM state enum (IDLE, BUSY, DONE)
- One sub-module, mdu_iter_datapath: a combinational single-iteration step for shift-add and restoring-divide.
- mdu_sequencer owns the FSM, counter, operand and accumulator registers, and output muxing.

Test Plan:
- MUL 0x1234×0x0010, wb_ready=1 → alu_status 10 for cycles 1–16; cycle 17 res_valid=1, result=0x2340, alu_status=01; cycle 18 IDLE.
- MULHU 0xFFFF×0xFFFF, rd_in=4'h7 → result=0xFFFE, res_rd=7; MUL with the same operands → 0x0001.
- DIVU 100/7 → 0x000E; REMU 100/7 → 0x0002; DIVU 0xFFFF/0x0001 → 0xFFFF.
- DIVU 0x1234/0 → DONE on cycle 1 after accept, result=0xFFFF, dbz=1; REMU 0x1234/0 → result 0x1234, dbz=1.
- wb_ready low for 3 cycles in DONE → alu_status=11 and result stable for those cycles, then 01 for one cycle; a start pulsed during the hold is ignored.
- flush at BUSY cycle 8, and separately rst_n low at BUSY cycle 5 → IDLE with all outputs 0; a new MUL 3×5 afterwards returns 0x000F at cycle 17.
